// File: rtl/ryuki_datatypes.sv
`default_nettype none
// ============================================================================
//  Module      : ryuki_datatypes (package)
//  Description : Shared trace record layout, stage indices and tracker FSM
//                encoding for the per-stage trace trackers.
//  Revision    : 1.0 - initial parametrised tracker release
// ============================================================================
package ryuki_datatypes;

   localparam int c_NUM_STAGES = 4;
   localparam int c_TS_WIDTH   = 32;

   localparam int IF_STAGE = 0;
   localparam int ID_STAGE = 1;
   localparam int EX_STAGE = 2;
   localparam int WB_STAGE = 3;

   typedef struct packed {
      logic [c_TS_WIDTH-1:0] time_start;
      logic [c_TS_WIDTH-1:0] time_end;
   } stage_time_t;

   typedef struct packed {
      stage_time_t [c_NUM_STAGES-1:0] stage;
      logic                           pass_through;
   } trace_output;

   localparam int c_TRACE_W = $bits(trace_output);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HOLD   = 2'd2
   } tracker_state_t;

   // Marks an element as flushed; optionally wipes the records of every
   // stage the element will now never legitimately reach.
   function automatic trace_output apply_kill(input trace_output t,
                                              input int          stage_idx,
                                              input logic        clear_later);
      trace_output r;
      r = t;
      r.pass_through = 1'b1;
      if (clear_later) begin
         for (int i = 0; i < c_NUM_STAGES; i++) begin
            if (i > stage_idx) begin
               r.stage[i] = '0;
            end
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Generic power-of-two FIFO with wrap-bit pointers, full/empty
//                flags and fill level. Head is readable combinationally; a
//                pushed entry becomes visible on the following cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
   parameter  int DEPTH = 4,   // power of two, at least 2
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      occupancy
);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push_en;
   logic             w_pop_en;

   // Extra MSB distinguishes a full buffer from an empty one.
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign occupancy = r_wr_ptr - r_rd_ptr;
   assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

   // A push into a full FIFO is refused even when a pop frees a slot this cycle.
   assign w_push_en = push && !full;
   assign w_pop_en  = pop && !empty;

   // Pointer update; natural overflow of the AW+1 bit pointers gives the wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (w_push_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/stage_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : stage_tracker
//  Description : Per-stage trace tracker. Queues trace records from the
//                upstream tracker, stamps this stage's start/end times from
//                the shared counter, applies jump-kill marking and hands the
//                completed record downstream over valid/ready.
//  Options     : TRACKER_DROP_ON_FULL_EN - never back-pressure upstream;
//                inputs arriving while full are dropped and counted on
//                drop_count (saturating).
//  Revision    : 1.0 - initial parametrised tracker release
// ============================================================================
module stage_tracker
   import ryuki_datatypes::*;
#(
   parameter  int QUEUE_DEPTH       = 4,
   parameter  int COUNTER_WIDTH     = 32,
   parameter  int STAGE             = 1,
   parameter  int KILL_CLEARS_LATER = 1,
   localparam int OCC_W             = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [COUNTER_WIDTH-1:0] counter,
   input  logic                     in_valid,
   input  trace_output              in_data,
   output logic                     in_ready,
   input  logic                     stage_active,
   input  logic                     kill,
   output logic                     out_valid,
   output trace_output              out_data,
   input  logic                     out_ready,
   output logic [OCC_W-1:0]         occupancy
`ifdef TRACKER_DROP_ON_FULL_EN
   ,
   output logic [15:0]              drop_count
`endif
);

   localparam logic c_CLEAR_LATER = (KILL_CLEARS_LATER != 0);

   tracker_state_t           r_state;
   tracker_state_t           w_state_next;
   trace_output              r_work;
   trace_output              w_work_next;
   logic                     r_out_valid;
   logic                     w_out_valid_next;
   logic                     w_fifo_push;
   logic                     w_fifo_pop;
   logic                     w_full;
   logic                     w_empty;
   logic [c_TRACE_W-1:0]     w_head_bits;
   trace_output              w_head;
   logic [c_TS_WIDTH-1:0]    w_stamp;

   // Timestamps are raw counter samples resized to the record field width.
   assign w_stamp   = c_TS_WIDTH'(counter);
   assign w_head    = w_head_bits;
   assign out_valid = r_out_valid;
   assign out_data  = r_work;

`ifdef TRACKER_DROP_ON_FULL_EN
   logic [15:0] r_drop_count;

   assign in_ready    = 1'b1;
   assign w_fifo_push = in_valid && !w_full;
   assign drop_count  = r_drop_count;

   // Count inputs lost to a full queue, sticking at the maximum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_count <= '0;
      end else if (in_valid && w_full && (r_drop_count != 16'hFFFF)) begin
         r_drop_count <= r_drop_count + 16'd1;
      end
   end
`else
   assign in_ready    = !w_full;
   assign w_fifo_push = in_valid && in_ready;
`endif

   trace_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (c_TRACE_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_fifo_push),
      .push_data (in_data),
      .pop       (w_fifo_pop),
      .pop_data  (w_head_bits),
      .full      (w_full),
      .empty     (w_empty),
      .occupancy (occupancy)
   );

   // FSM state, working record and output-valid registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_work      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_work      <= w_work_next;
         r_out_valid <= w_out_valid_next;
      end
   end

   // Next-state, timestamping and kill marking for the element in flight.
   always_comb begin
      w_state_next     = r_state;
      w_work_next      = r_work;
      w_out_valid_next = r_out_valid;
      w_fifo_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            // Stage activity with nothing queued is simply not traced.
            if (stage_active && !w_empty) begin
               w_fifo_pop                         = 1'b1;
               w_work_next                        = w_head;
               w_work_next.stage[STAGE].time_start = w_stamp;
               if (kill) begin
                  w_work_next = apply_kill(w_work_next, STAGE, c_CLEAR_LATER);
               end
               w_state_next = ACTIVE;
            end
         end
         ACTIVE: begin
            if (kill) begin
               w_work_next = apply_kill(w_work_next, STAGE, c_CLEAR_LATER);
            end
            if (!stage_active) begin
               w_work_next.stage[STAGE].time_end = w_stamp;
               w_out_valid_next                  = 1'b1;
               w_state_next                      = HOLD;
            end
         end
         HOLD: begin
            // Record is frozen here; kill and new activity are ignored.
            if (out_ready) begin
               w_out_valid_next = 1'b0;
               w_state_next     = IDLE;
            end
         end
         default: begin
            w_out_valid_next = 1'b0;
            w_state_next     = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_stage_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_tracker
//  Description : Directed bench for stage_tracker (STAGE=1, QUEUE_DEPTH=4).
//                Stimulus pushes expected records into a scoreboard queue; a
//                monitor pops and compares on each downstream handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_tracker;
   import ryuki_datatypes::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] counter;
   logic        in_valid;
   trace_output in_data;
   logic        in_ready;
   logic        stage_active;
   logic        kill;
   logic        out_valid;
   trace_output out_data;
   logic        out_ready;
   logic [2:0]  occupancy;
`ifdef TRACKER_DROP_ON_FULL_EN
   logic [15:0] drop_count;
`endif

   trace_output exp_q[$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stage_tracker #(
      .QUEUE_DEPTH       (4),
      .COUNTER_WIDTH     (32),
      .STAGE             (1),
      .KILL_CLEARS_LATER (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .counter      (counter),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .stage_active (stage_active),
      .kill         (kill),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .occupancy    (occupancy)
`ifdef TRACKER_DROP_ON_FULL_EN
      ,
      .drop_count   (drop_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
      counter = counter + 32'd1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_elem(input string name, input trace_output act, input trace_output req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic trace_output make_elem(input int seed);
      trace_output e;
      e = '0;
      for (int i = 0; i < 4; i++) begin
         e.stage[i].time_start = 32'(seed * 256 + i * 16 + 1);
         e.stage[i].time_end   = 32'(seed * 256 + i * 16 + 2);
      end
      return e;
   endfunction

   task automatic push_elem(input trace_output e);
      in_valid = 1'b1;
      in_data  = e;
      tick();
      in_valid = 1'b0;
   endtask

   // Drives one stage burst of n_active cycles (first cycle pops), optional kill
   // in burst cycle kill_at, and queues the expected record for STAGE=1.
   task automatic run_stage(input trace_output base, input int n_active,
                            input int kill_at, input bit finish,
                            output trace_output e);
      e = base;
      stage_active = 1'b1;
      e.stage[1].time_start = counter;
      for (int k = 0; k < n_active; k++) begin
         kill = (k == kill_at);
         tick();
      end
      kill         = 1'b0;
      stage_active = 1'b0;
      e.stage[1].time_end = counter;
      if (kill_at >= 0) begin
         e.pass_through = 1'b1;
         e.stage[2]     = '0;
         e.stage[3]     = '0;
      end
      exp_q.push_back(e);
      tick();
      if (finish) begin
         tick();
      end
   endtask

   // Scoreboard monitor: compare on every handshake, flag unexpected output.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out actual=%h required=none", out_data);
         end else if (out_ready) begin
            check_elem("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      trace_output e;
      rst          = 1'b1;
      counter      = 32'd0;
      in_valid     = 1'b0;
      in_data      = '0;
      stage_active = 1'b0;
      kill         = 1'b0;
      out_ready    = 1'b1;
      tick();
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check_elem("rst_out_data", out_data, '0);
      rst = 1'b0;
      tick();

      // Basic trace: push at counter 10, active 12..14, falls at 15.
      counter = 32'd10;
      push_elem(make_elem(1));
      tick();
      check("t2_counter_start", counter, 32'd12);
      run_stage(make_elem(1), 3, -1, 1'b1, e);
      check("t2_start", e.stage[1].time_start, 32'd12);
      check("t2_end",   e.stage[1].time_end,   32'd15);
      check("t2_valid_one_cycle", 32'(out_valid), 32'd0);
      check("t2_occupancy", 32'(occupancy), 32'd0);

      // Kill during ACTIVE, and kill on the pop cycle.
      push_elem(make_elem(2));
      run_stage(make_elem(2), 3, 1, 1'b1, e);
      push_elem(make_elem(3));
      run_stage(make_elem(3), 2, 0, 1'b1, e);

`ifndef TRACKER_DROP_ON_FULL_EN
      // Full FIFO refuses a push even with a simultaneous pop.
      for (int i = 0; i < 4; i++) begin
         push_elem(make_elem(10 + i));
      end
      check("t3_full_ready", 32'(in_ready), 32'd0);
      check("t3_full_occ", 32'(occupancy), 32'd4);
      in_valid     = 1'b1;
      in_data      = make_elem(99);
      stage_active = 1'b1;
      e            = make_elem(10);
      e.stage[1].time_start = counter;
      tick();
      in_valid = 1'b0;
      check("t3_occ_after", 32'(occupancy), 32'd3);
      check("t3_ready_after", 32'(in_ready), 32'd1);
      stage_active = 1'b0;
      e.stage[1].time_end = counter;
      exp_q.push_back(e);
      tick();
      tick();
      for (int i = 1; i < 4; i++) begin
         run_stage(make_elem(10 + i), 1, -1, 1'b1, e);
      end
      check("t3_drained", 32'(occupancy), 32'd0);
`endif

      // HOLD with out_ready low: data stable, second burst not popped.
      push_elem(make_elem(20));
      push_elem(make_elem(21));
      out_ready = 1'b0;
      run_stage(make_elem(20), 2, -1, 1'b0, e);
      for (int i = 0; i < 5; i++) begin
         check("t5_hold_valid", 32'(out_valid), 32'd1);
         check_elem("t5_hold_data", out_data, e);
         check("t5_hold_occ", 32'(occupancy), 32'd1);
         stage_active = (i >= 1);
         tick();
      end
      stage_active = 1'b0;
      out_ready    = 1'b1;
      tick();
      check("t5_after_occ", 32'(occupancy), 32'd1);
      run_stage(make_elem(21), 1, -1, 1'b1, e);

      // Asynchronous reset mid-ACTIVE with three entries queued.
      for (int i = 0; i < 4; i++) begin
         push_elem(make_elem(30 + i));
      end
      stage_active = 1'b1;
      tick();
      tick();
      check("t1_pre_occ", 32'(occupancy), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("t1_rst_valid", 32'(out_valid), 32'd0);
      check("t1_rst_occ",   32'(occupancy), 32'd0);
      check("t1_rst_ready", 32'(in_ready),  32'd1);
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("t1_post_occ", 32'(occupancy), 32'd0);
      stage_active = 1'b0;
      tick();
      tick();
      check("t1_post_valid", 32'(out_valid), 32'd0);

`ifdef TRACKER_DROP_ON_FULL_EN
      // Six pushes into an empty 4-deep FIFO without pops.
      for (int i = 0; i < 6; i++) begin
         push_elem(make_elem(40 + i));
      end
      check("t6_occ", 32'(occupancy), 32'd4);
      check("t6_drop", 32'(drop_count), 32'd2);
      check("t6_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         run_stage(make_elem(40 + i), 1, -1, 1'b1, e);
      end
`endif

      tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
